// File: rtl/parking_ctrl_n.sv
// parking_ctrl_n -- parking lot entry/exit controller for NUM_SPOTS spots.
//
// Keeps an occupancy bitmap and count, allocates the lowest-index free spot
// to each entry request, drives a timed entry door and flags invalid exits.
//
// Parameters:
//   NUM_SPOTS   number of spots (2..64)
//   DOOR_CYCLES cycles door_open stays high after a grant (>=1)
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous active-high reset
//   entry_req     car at entry gate (level, held until grant/reject)
//   exit_req      single-cycle exit pulse
//   exit_slot     slot being vacated, valid with exit_req
//   entry_grant   one-cycle pulse: spot allocated
//   entry_reject  one-cycle pulse: lot full
//   granted_slot  slot of the last grant, held until the next grant
//   door_open     entry door actuator
//   is_full       count == NUM_SPOTS
//   occupancy     bit i = spot i occupied
//   count         number of occupied spots
//   dbg_state     current entry FSM state (CLOSED=0, OPEN=1, REJ_WAIT=2)
//   exit_err      one-cycle pulse: exit of a free or nonexistent spot
//
// Optional build macro PARK_STATS_EN adds total_entries / total_rejects,
// saturating 16-bit counters of grants and rejects.
//
// Handshake: entry_req is a level request; exactly one of entry_grant or
// entry_reject pulses one cycle after it is first sampled in CLOSED. The
// requester drops entry_req after seeing either pulse.

module parking_ctrl_n #(
    parameter  int NUM_SPOTS   = 8,
    parameter  int DOOR_CYCLES = 4,
    localparam int SLOT_W      = $clog2(NUM_SPOTS),
    localparam int CNT_W       = $clog2(NUM_SPOTS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 entry_req,
    input  logic                 exit_req,
    input  logic [SLOT_W-1:0]    exit_slot,
    output logic                 entry_grant,
    output logic                 entry_reject,
    output logic [SLOT_W-1:0]    granted_slot,
    output logic                 door_open,
    output logic                 is_full,
    output logic [NUM_SPOTS-1:0] occupancy,
    output logic [CNT_W-1:0]     count,
    output logic [1:0]           dbg_state,
    output logic                 exit_err
`ifdef PARK_STATS_EN
    ,
    output logic [15:0]          total_entries,
    output logic [15:0]          total_rejects
`endif
);

    localparam int DC_W = $clog2(DOOR_CYCLES + 1);

    typedef enum logic [1:0] {
        CLOSED   = 2'd0,
        OPEN     = 2'd1,
        REJ_WAIT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DC_W-1:0]       door_cnt_q, door_cnt_d;
    logic [NUM_SPOTS-1:0]  occ_q, occ_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SLOT_W-1:0]     gslot_q, gslot_d;
    logic                  grant_q, grant_d;
    logic                  reject_q, reject_d;
    logic                  err_q, err_d;

    logic [SLOT_W-1:0]     free_idx;
    logic [NUM_SPOTS-1:0]  alloc_mask;
    logic [NUM_SPOTS-1:0]  exit_mask;
    logic                  exit_in_range;
    logic                  exit_ok;
    logic                  inc;

    // Lowest-index free spot: scanning downward lets the lowest index win.
    always_comb begin
        free_idx = '0;
        for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
            if (!occ_q[i]) begin
                free_idx = SLOT_W'(i);
            end
        end
    end

    assign alloc_mask    = {{(NUM_SPOTS-1){1'b0}}, 1'b1} << free_idx;
    assign exit_mask     = {{(NUM_SPOTS-1){1'b0}}, 1'b1} << exit_slot;
    // Widen before comparing so non-power-of-two lots reject slot indices
    // that exist in the encoding but not in the lot.
    assign exit_in_range = ({{(32-SLOT_W){1'b0}}, exit_slot} < 32'(NUM_SPOTS));
    assign exit_ok       = exit_req && exit_in_range && (|(occ_q & exit_mask));

    always_comb begin
        state_d    = state_q;
        door_cnt_d = door_cnt_q;
        occ_d      = occ_q;
        cnt_d      = cnt_q;
        gslot_d    = gslot_q;
        grant_d    = 1'b0;
        reject_d   = 1'b0;
        err_d      = 1'b0;
        inc        = 1'b0;

        case (state_q)
            CLOSED: begin
                // Full check and allocation use pre-exit occupancy, so a
                // spot freed this cycle is never handed out on the same edge.
                if (entry_req) begin
                    if (!is_full) begin
                        occ_d      = occ_q | alloc_mask;
                        gslot_d    = free_idx;
                        grant_d    = 1'b1;
                        inc        = 1'b1;
                        door_cnt_d = DC_W'(DOOR_CYCLES);
                        state_d    = OPEN;
                    end else begin
                        reject_d = 1'b1;
                        state_d  = REJ_WAIT;
                    end
                end
            end
            OPEN: begin
                door_cnt_d = door_cnt_q - DC_W'(1);
                if (door_cnt_q == DC_W'(1)) begin
                    state_d = CLOSED;
                end
            end
            REJ_WAIT: begin
                if (!entry_req) begin
                    state_d = CLOSED;
                end
            end
            default: begin
                state_d = CLOSED;
            end
        endcase

        // The exit bit is occupied and the allocated bit was free, so the
        // two updates never touch the same spot.
        if (exit_ok) begin
            occ_d = occ_d & ~exit_mask;
        end else if (exit_req) begin
            err_d = 1'b1;
        end

        if (inc && !exit_ok) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!inc && exit_ok) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CLOSED;
            door_cnt_q <= '0;
            occ_q      <= '0;
            cnt_q      <= '0;
            gslot_q    <= '0;
            grant_q    <= 1'b0;
            reject_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            door_cnt_q <= door_cnt_d;
            occ_q      <= occ_d;
            cnt_q      <= cnt_d;
            gslot_q    <= gslot_d;
            grant_q    <= grant_d;
            reject_q   <= reject_d;
            err_q      <= err_d;
        end
    end

    assign entry_grant  = grant_q;
    assign entry_reject = reject_q;
    assign granted_slot = gslot_q;
    assign door_open    = (state_q == OPEN);
    assign is_full      = (cnt_q == CNT_W'(NUM_SPOTS));
    assign occupancy    = occ_q;
    assign count        = cnt_q;
    assign dbg_state    = state_q;
    assign exit_err     = err_q;

`ifdef PARK_STATS_EN
    logic [15:0] entries_q;
    logic [15:0] rejects_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            entries_q <= '0;
            rejects_q <= '0;
        end else begin
            if (grant_d && (entries_q != 16'hFFFF)) begin
                entries_q <= entries_q + 16'd1;
            end
            if (reject_d && (rejects_q != 16'hFFFF)) begin
                rejects_q <= rejects_q + 16'd1;
            end
        end
    end

    assign total_entries = entries_q;
    assign total_rejects = rejects_q;
`endif

endmodule
